// File: rtl/operand_fetch_unit.sv
// Operand-fetch stage: GR/FP register banks, per-register busy scoreboard,
// write-back bypass, RAW/WAW stall and a registered valid/ready output stage.
module operand_fetch_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      iValidInstruction,
  output logic                      oReady,
  input  logic                      iFp,
  input  logic [REG_ADDR_WIDTH-1:0] iRs,
  input  logic [REG_ADDR_WIDTH-1:0] iRt,
  input  logic [REG_ADDR_WIDTH-1:0] iRd,
  input  logic                      iWrEn,
  input  logic [IMM_WIDTH-1:0]      iImmediate,
  input  logic                      iWbValid,
  input  logic                      iWbFp,
  input  logic [REG_ADDR_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0]     iWbData,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [DATA_WIDTH-1:0]     oRsData,
  output logic [DATA_WIDTH-1:0]     oRtData,
  output logic [REG_ADDR_WIDTH-1:0] oRd,
  output logic                      oFp,
  output logic                      oWrEn,
  output logic [IMM_WIDTH-1:0]      oImmediate
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gr_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] fp_q [NUM_REGS];
  logic [NUM_REGS-1:0]   gr_busy_q, gr_busy_d;
  logic [NUM_REGS-1:0]   fp_busy_q, fp_busy_d;

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     rs_data_q, rt_data_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      fp_q_out, wr_en_q;
  logic [IMM_WIDTH-1:0]      imm_q;

  logic                  rs_gr0, rt_gr0, rd_gr0;
  logic                  rs_bypass, rt_bypass, rd_clear;
  logic                  rs_busy, rt_busy, rd_busy;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  logic                  hazard, accept;

  always_comb begin
    rs_gr0 = !iFp && (iRs == '0);
    rt_gr0 = !iFp && (iRt == '0);
    rd_gr0 = !iFp && (iRd == '0);

    rs_bypass = iWbValid && (iWbFp == iFp) && (iWbAddr == iRs) && !rs_gr0;
    rt_bypass = iWbValid && (iWbFp == iFp) && (iWbAddr == iRt) && !rt_gr0;
    rd_clear  = iWbValid && (iWbFp == iFp) && (iWbAddr == iRd);

    rs_busy = iFp ? fp_busy_q[iRs] : gr_busy_q[iRs];
    rt_busy = iFp ? fp_busy_q[iRt] : gr_busy_q[iRt];
    rd_busy = iFp ? fp_busy_q[iRd] : gr_busy_q[iRd];

    if (rs_gr0)         rs_data = '0;
    else if (rs_bypass) rs_data = iWbData;
    else                rs_data = iFp ? fp_q[iRs] : gr_q[iRs];

    if (rt_gr0)         rt_data = '0;
    else if (rt_bypass) rt_data = iWbData;
    else                rt_data = iFp ? fp_q[iRt] : gr_q[iRt];

    hazard = (rs_busy && !rs_bypass) || (rt_busy && !rt_bypass) ||
             (iWrEn && rd_busy && !rd_clear);
    oReady = !hazard && (!valid_q || iReady);
    accept = iValidInstruction && oReady;
  end

  // NOTE: in combinational blocks use blocking '=' and give every output a
  // default first; here the accept-set is written after the write-back clear
  // so the set wins when both target the same bit.
  always_comb begin
    gr_busy_d = gr_busy_q;
    fp_busy_d = fp_busy_q;
    if (iWbValid) begin
      if (iWbFp) fp_busy_d[iWbAddr] = 1'b0;
      else       gr_busy_d[iWbAddr] = 1'b0;
    end
    if (accept && iWrEn && !rd_gr0) begin
      if (iFp) fp_busy_d[iRd] = 1'b1;
      else     gr_busy_d[iRd] = 1'b1;
    end
    gr_busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking '<='. The banks are reset
  // explicitly because software may read any register straight after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gr_q[i] <= '0;
        fp_q[i] <= '0;
      end
      gr_busy_q <= '0;
      fp_busy_q <= '0;
    end else begin
      gr_busy_q <= gr_busy_d;
      fp_busy_q <= fp_busy_d;
      if (iWbValid) begin
        if (iWbFp)                 fp_q[iWbAddr] <= iWbData;
        else if (iWbAddr != '0)    gr_q[iWbAddr] <= iWbData;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rd_q      <= '0;
      fp_q_out  <= 1'b0;
      wr_en_q   <= 1'b0;
      imm_q     <= '0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
      rd_q      <= iRd;
      fp_q_out  <= iFp;
      wr_en_q   <= iWrEn;
      imm_q     <= iImmediate;
    end else if (valid_q && iReady) begin
      valid_q   <= 1'b0;
    end
  end

  assign oValid     = valid_q;
  assign oRsData    = rs_data_q;
  assign oRtData    = rt_data_q;
  assign oRd        = rd_q;
  assign oFp        = fp_q_out;
  assign oWrEn      = wr_en_q;
  assign oImmediate = imm_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: directed scenarios plus random
// traffic checked against a register-file/busy-table reference model.
module tb_operand_fetch_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          iValidInstruction, oReady, iFp, iWrEn;
  logic [AW-1:0] iRs, iRt, iRd, iWbAddr, oRd;
  logic [IW-1:0] iImmediate, oImmediate;
  logic          iWbValid, iWbFp, oValid, iReady, oFp, oWrEn;
  logic [DW-1:0] iWbData, oRsData, oRtData;

  always #5 clk = ~clk;

  operand_fetch_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .IMM_WIDTH(IW)) dut (
    .clk(clk), .resetn(resetn),
    .iValidInstruction(iValidInstruction), .oReady(oReady),
    .iFp(iFp), .iRs(iRs), .iRt(iRt), .iRd(iRd), .iWrEn(iWrEn),
    .iImmediate(iImmediate),
    .iWbValid(iWbValid), .iWbFp(iWbFp), .iWbAddr(iWbAddr), .iWbData(iWbData),
    .oValid(oValid), .iReady(iReady),
    .oRsData(oRsData), .oRtData(oRtData), .oRd(oRd), .oFp(oFp),
    .oWrEn(oWrEn), .oImmediate(oImmediate)
  );

  typedef struct packed {
    logic          v;
    logic          fp;
    logic [AW-1:0] rs, rt, rd;
    logic          wren;
    logic [IW-1:0] imm;
    logic          wbv, wbfp;
    logic [AW-1:0] wba;
    logic [DW-1:0] wbd;
    logic          rdy;
  } stim_t;

  typedef struct packed {
    logic [DW-1:0] rs_data, rt_data;
    logic [AW-1:0] rd;
    logic          fp, wren;
    logic [IW-1:0] imm;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_reg  [2][32];
  logic          m_busy [2][32];
  logic          m_valid;
  logic          last_ready;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 32; r++) begin
        m_reg[b][r]  = '0;
        m_busy[b][r] = 1'b0;
      end
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic logic wb_hits(input stim_t s, input logic [AW-1:0] a);
    return s.wbv && (s.wbfp == s.fp) && (s.wba == a);
  endfunction

  function automatic logic [DW-1:0] src_val(input stim_t s, input logic [AW-1:0] a);
    if (!s.fp && a == 0) return '0;
    if (wb_hits(s, a))   return s.wbd;
    return m_reg[s.fp][a];
  endfunction

  function automatic logic free(input stim_t s, input logic [AW-1:0] a);
    return !m_busy[s.fp][a] || wb_hits(s, a);
  endfunction

  task automatic drive(input stim_t s);
    iValidInstruction = s.v;    iFp = s.fp;
    iRs = s.rs; iRt = s.rt; iRd = s.rd;
    iWrEn = s.wren;             iImmediate = s.imm;
    iWbValid = s.wbv; iWbFp = s.wbfp; iWbAddr = s.wba; iWbData = s.wbd;
    iReady = s.rdy;
  endtask

  // One cycle: drive after the edge, check oReady/oValid, record the expected
  // output on accept, then advance the model to the state after the next edge.
  task automatic apply(input stim_t s);
    logic rdy_exp, acc;
    exp_t e;
    @(posedge clk);
    #1 drive(s);
    #1;
    rdy_exp = free(s, s.rs) && free(s, s.rt) && !(s.wren && !free(s, s.rd)) &&
              (!m_valid || s.rdy);
    check("oReady", 64'(oReady), 64'(rdy_exp));
    check("oValid", 64'(oValid), 64'(m_valid));
    last_ready = oReady;
    acc = s.v && rdy_exp;
    if (acc) begin
      e.rs_data = src_val(s, s.rs);
      e.rt_data = src_val(s, s.rt);
      e.rd      = s.rd;
      e.fp      = s.fp;
      e.wren    = s.wren;
      e.imm     = s.imm;
      exp_q.push_back(e);
    end
    if (s.wbv) begin
      if (s.wbfp || s.wba != 0) m_reg[s.wbfp][s.wba] = s.wbd;
      m_busy[s.wbfp][s.wba] = 1'b0;
    end
    if (acc && s.wren && (s.fp || s.rd != 0)) m_busy[s.fp][s.rd] = 1'b1;
    if (acc)                  m_valid = 1'b1;
    else if (m_valid && s.rdy) m_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_oValid"},     64'(oValid),     64'd0);
    check({tag, "_oRsData"},    64'(oRsData),    64'd0);
    check({tag, "_oRtData"},    64'(oRtData),    64'd0);
    check({tag, "_oRd"},        64'(oRd),        64'd0);
    check({tag, "_oFp"},        64'(oFp),        64'd0);
    check({tag, "_oWrEn"},      64'(oWrEn),      64'd0);
    check({tag, "_oImmediate"}, 64'(oImmediate), 64'd0);
  endtask

  // Monitor: every output the execute stage consumes must match the oldest
  // expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && oValid && iReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("oRsData",    64'(oRsData),    64'(e.rs_data));
          check("oRtData",    64'(oRtData),    64'(e.rt_data));
          check("oRd",        64'(oRd),        64'(e.rd));
          check("oFp",        64'(oFp),        64'(e.fp));
          check("oWrEn",      64'(oWrEn),      64'(e.wren));
          check("oImmediate", 64'(oImmediate), 64'(e.imm));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [86:0] snap;
    drive(idle());
    resetn = 1'b0;
    model_reset();
    #12 check_outputs_zero("reset");
    @(negedge clk) resetn = 1'b1;

    // Bank selection: GR5 and FP5 hold different values.
    s = idle(); s.wbv = 1; s.wba = 5; s.wbd = 32'h1234;              apply(s);
    s = idle(); s.wbv = 1; s.wbfp = 1; s.wba = 5; s.wbd = 32'hABCD;  apply(s);
    s = idle(); s.v = 1; s.rs = 5;                                   apply(s);
    apply(idle());
    check("gr5_read", 64'(oRsData), 64'h1234);
    s = idle(); s.v = 1; s.fp = 1; s.rs = 5;                         apply(s);
    apply(idle());
    check("fp5_read", 64'(oRsData), 64'hABCD);

    // RAW stall on GR3 released by a bypassed write-back.
    s = idle(); s.v = 1; s.rd = 3; s.wren = 1;                       apply(s);
    s = idle(); s.v = 1; s.rs = 3;
    for (int i = 0; i < 3; i++) begin
      apply(s);
      check("raw_stall", 64'(last_ready), 64'd0);
    end
    s.wbv = 1; s.wba = 3; s.wbd = 32'h55;                            apply(s);
    check("raw_release", 64'(last_ready), 64'd1);
    apply(idle());
    check("raw_bypass_data", 64'(oRsData), 64'h55);

    // GR0: writes discarded, never busy.
    s = idle(); s.wbv = 1; s.wba = 0; s.wbd = 32'hFFFF;              apply(s);
    s = idle(); s.v = 1; s.rd = 0; s.wren = 1;                       apply(s);
    s = idle(); s.v = 1; s.rs = 0;                                   apply(s);
    check("gr0_no_stall", 64'(last_ready), 64'd1);
    apply(idle());
    check("gr0_reads_zero", 64'(oRsData), 64'd0);
    apply(idle());

    // Backpressure: outputs hold while iReady is low.
    s = idle(); s.v = 1; s.rs = 5; s.imm = 16'h7777; s.rdy = 0;     apply(s);
    s = idle(); s.v = 1; s.rs = 1; s.imm = 16'h1111; s.rdy = 0;
    apply(s);
    snap = {oRsData, oRtData, oRd, oFp, oWrEn, oImmediate};
    check("bp_held_imm", 64'(oImmediate), 64'h7777);
    for (int i = 0; i < 5; i++) begin
      apply(s);
      check("bp_not_ready", 64'(last_ready), 64'd0);
      check("bp_stable", 64'(snap != {oRsData, oRtData, oRd, oFp, oWrEn, oImmediate}), 64'd0);
    end
    s = idle(); s.v = 1; s.rs = 2; s.imm = 16'h8888;                apply(s);
    check("bp_release_ready", 64'(last_ready), 64'd1);
    apply(idle());
    check("bp_next_loaded", 64'(oImmediate), 64'h8888);

    // WAW on FP7 with simultaneous clear and set: set wins.
    s = idle(); s.v = 1; s.fp = 1; s.rd = 7; s.wren = 1;             apply(s);
    s.wbv = 1; s.wbfp = 1; s.wba = 7; s.wbd = 32'h77;                apply(s);
    check("waw_accept", 64'(last_ready), 64'd1);
    s = idle(); s.v = 1; s.fp = 1; s.rs = 7;                         apply(s);
    check("fp7_still_busy", 64'(last_ready), 64'd0);

    // Reset in the middle of a stall on GR3.
    s = idle(); s.v = 1; s.rd = 3; s.wren = 1;                       apply(s);
    s = idle(); s.v = 1; s.rs = 3;                                   apply(s);
    check("pre_reset_stall", 64'(last_ready), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b0;
    drive(idle());
    model_reset();
    #1 check_outputs_zero("midreset");
    @(negedge clk) resetn = 1'b1;
    s = idle(); s.v = 1; s.rs = 3;                                   apply(s);
    check("post_reset_no_stall", 64'(last_ready), 64'd1);
    apply(idle());
    check("post_reset_gr3_zero", 64'(oRsData), 64'd0);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.v    = ($urandom_range(0, 9) < 7);
      s.fp   = $urandom_range(0, 1);
      s.rs   = AW'($urandom_range(0, 7));
      s.rt   = AW'($urandom_range(0, 7));
      s.rd   = AW'($urandom_range(0, 7));
      s.wren = $urandom_range(0, 1);
      s.imm  = IW'($urandom);
      s.wbv  = ($urandom_range(0, 9) < 4);
      s.wbfp = $urandom_range(0, 1);
      s.wba  = AW'($urandom_range(0, 7));
      s.wbd  = $urandom;
      s.rdy  = ($urandom_range(0, 3) != 0);
      apply(s);
    end

    for (int i = 0; i < 3; i++) apply(idle());
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Parametrised operand-fetch stage between decode and execute. It holds separate general-purpose (GR) and floating-point (FP) register banks and a per-register busy scoreboard. Each cycle it accepts one decoded instruction, reads the source operands from the selected bank with write-back bypass, and stalls on RAW/WAW hazards. Operands are presented to execute through a registered valid/ready stage.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width (bits)
- REG_ADDR_WIDTH, 5, register index width; each bank holds 2**REG_ADDR_WIDTH entries
- IMM_WIDTH, 16, immediate width, passed through unchanged

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  reset, asynchronous, active-low
- iValidInstruction  in  1  decoded instruction present
- oReady  out  1  stage accepts the instruction this cycle (combinational)
- iFp  in  1  0 = GR bank, 1 = FP bank; applies to rs, rt and rd
- iRs, iRt, iRd  in  REG_ADDR_WIDTH each  source and destination indices
- iWrEn  in  1  instruction writes rd
- iImmediate  in  IMM_WIDTH  immediate field
- iWbValid  in  1  write-back strobe
- iWbFp  in  1  write-back bank select
- iWbAddr  in  REG_ADDR_WIDTH  write-back index
- iWbData  in  DATA_WIDTH  write-back data
- oValid  out  1  output stage holds an instruction
- iReady  in  1  execute consumes the output this cycle
- oRsData, oRtData  out  DATA_WIDTH each  operand values
- oRd  out  REG_ADDR_WIDTH  destination index
- oFp  out  1  bank of the output instruction
- oWrEn  out  1  output instruction writes rd
- oImmediate  out  IMM_WIDTH  immediate

## Operation
- Register 0 in the GR bank reads as 0. Writes to it are discarded and it is never marked busy. FP register 0 is an ordinary register.
- Scoreboard: one busy bit per register per bank.
- Write-back: when iWbValid is high, write iWbData into bank iWbFp at iWbAddr and clear that busy bit.
- Source read uses bypass. If iWbValid, iWbFp==iFp, iWbAddr==src and the source is not GR0, the operand is iWbData. Otherwise it is the array value.
- Hazard is raised when either of these holds:
  - RAW: rs or rt is busy in bank iFp and is not bypassed this cycle.
  - WAW: iWrEn and rd is busy in bank iFp and is not being cleared by write-back this cycle.
- oReady = !hazard && (!oValid || iReady).
- Accept = iValidInstruction && oReady. On accept:
  - Output registers load the operands, rd, iFp, iWrEn and the immediate, and oValid is set to 1.
  - If iWrEn and the destination is not GR0, set busy[iFp][iRd].
- If a write-back clears a bit and an accept sets the same bit in the same cycle, the set wins (the bit ends busy).
- If oValid && iReady && !accept, oValid goes to 0. While oValid && !iReady, all outputs hold stable.
- rs, rt and rd always use the same bank, selected by iFp. Cross-bank moves are outside this block.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- A write-back at edge N is visible in the array read from cycle N+1. In the same cycle it is visible through the bypass.
- Throughput is one instruction per cycle when there is no hazard and iReady is held high.
- oReady is combinational from iRs/iRt/iRd/iFp/iWrEn, the iWb* inputs, the scoreboard, oValid and iReady.
- Reset (asserted at any time, including mid-stall) clears:
  - all registers in both banks to 0
  - all busy bits
  - oValid, oRsData, oRtData, oRd, oFp, oWrEn and oImmediate to 0
- Instructions in flight during reset are lost.
- No other state is held; the block has no FSM beyond the output-valid bit and the scoreboard.

## Test plan
- Reset, then write back GR5=0x1234 and FP5=0xABCD. Issue rs=5 with iFp=0, then with iFp=1 -> oRsData is 0x1234, then 0xABCD; oValid is 1 the cycle after each accept.
- Issue GR rd=3 with iWrEn, then a GR instruction with rs=3 -> oReady is 0 until a write-back of GR3=0x55 arrives. In the write-back cycle oReady is 1 and oRsData registers 0x55 via the bypass.
- GR0: write back 0xFFFF to GR0, issue rd=0 with iWrEn, then read rs=0 -> no stall, oRsData is 0.
- Backpressure: hold iReady=0 with oValid=1 -> oReady is 0 and outputs stay stable for 5 cycles. Release iReady -> the next instruction loads in the same cycle.
- WAW plus simultaneous clear/set: FP rd=7 is busy; issue FP rd=7 while the write-back clears FP7 -> accepted, FP7 ends busy, and a following rs=7 stalls.
- Assert resetn low mid-stall -> all outputs are 0 and busy bits clear; a GR rs=3 read after reset returns 0 with no stall.
